// File: rtl/mem_port_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and limits for mem_port_arbiter           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter_if : fetch/data request ports and shared memory bus |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_port_arbiter_if;

  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [15:0] i_rdata;

  logic        d_req;
  logic [15:0] d_addr;
  logic [1:0]  d_we;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;

  logic [15:0] m_addr;
  logic        m_oe;
  logic [1:0]  m_we;
  logic [15:0] m_dout;
  logic [15:0] m_din;

  // Requesters and the memory model sit on the master side.
  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_wdata, m_din,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_addr, m_oe, m_we, m_dout
  );

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, m_din,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_addr, m_oe, m_we, m_dout
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
// +----------------------------------------------------------------------+
// | arb_pick : chooses the next port owner (fixed D priority, or         |
// |            round-robin when ARB_ROUND_ROBIN_EN is defined)           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output owner_t winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = OWN_D;
    if (i_req && d_req) begin
      winner = (last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (i_req) begin
      winner = OWN_I;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == OWN_D);

  always_comb begin
    winner = OWN_D;
    if (i_req && !d_req) begin
      winner = OWN_I;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter : shares one memory port between fetch and data     |
// |                    requesters; optional ARB_ROUND_ROBIN_EN macro      |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_t           owner_q, owner_d;
  logic [15:0]      addr_q, addr_d;
  logic [1:0]       we_q, we_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      i_rdata_q, i_rdata_d;
  logic [15:0]      d_rdata_q, d_rdata_d;
  logic             i_rvalid_q, i_rvalid_d;
  logic             d_rvalid_q, d_rvalid_d;

  owner_t winner;
  owner_t pick_last;
  logic   grant;
  logic   last_cycle;

  arb_pick u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_owner (pick_last),
    .winner     (winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (grant) begin
      last_d = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= OWN_I;
    end else begin
      last_q <= last_d;
    end
  end

  assign pick_last = last_q;
`else
  assign pick_last = OWN_I;
`endif

  // Grants are combinational so a new access can start in the rvalid cycle.
  assign grant      = rst && (state_q == IDLE) && (bus.i_req || bus.d_req);
  assign last_cycle = (state_q == ACCESS) && (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          owner_d = winner;
          if (winner == OWN_D) begin
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
          end else begin
            addr_d  = bus.i_addr;
            we_d    = 2'b00;
          end
        end
      end
      ACCESS: begin
        if (last_cycle) begin
          state_d = IDLE;
          if (owner_q == OWN_D) begin
            d_rdata_d  = bus.m_din;
            d_rvalid_d = 1'b1;
          end else begin
            i_rdata_d  = bus.m_din;
            i_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_I;
      addr_q     <= '0;
      we_q       <= 2'b00;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
    end
  end

  assign bus.i_gnt    = grant && (winner == OWN_I);
  assign bus.d_gnt    = grant && (winner == OWN_D);
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;

  // Address and write data stay on the bus between accesses.
  assign bus.m_addr = addr_q;
  assign bus.m_dout = wdata_q;
  assign bus.m_oe   = (state_q == ACCESS) && (we_q == 2'b00);
  assign bus.m_we   = last_cycle ? we_q : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter          |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  localparam int LAT = 3;

  typedef struct {
    bit          own_d;
    bit          chk_data;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus1 ();

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_port_arbiter #(.MEM_LAT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  exp_t        exp_q[$];
  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  bit          arb_exp [4];

  assign bus.m_din  = mem[bus.m_addr[8:1]];
  assign bus1.m_din = (bus1.m_addr == 16'h0010) ? 16'hA5A5 : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input bit is_d, input logic [15:0] a, input logic [1:0] we,
                          input logic [15:0] wd);
    exp_t e;
    e.own_d    = is_d;
    e.chk_data = (we == 2'b00);
    e.data     = ref_mem[a[8:1]];
    if (we[0]) ref_mem[a[8:1]][7:0]  = wd[7:0];
    if (we[1]) ref_mem[a[8:1]][15:8] = wd[15:8];
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit is_d, input logic [15:0] a, input logic [1:0] we,
                       input logic [15:0] wd);
    int n;
    @(posedge clk); #1;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_addr = a; bus.d_we = we; bus.d_wdata = wd;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = a;
    end
    n = 0;
    @(negedge clk);
    while (!(is_d ? bus.d_gnt : bus.i_gnt) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_timeout", 32'(n < 50), 1);
    push_exp(is_d, a, we, wd);
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we  = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 100), 1);
  endtask

  // Memory model: byte-enabled writes land during the write cycle.
  always @(negedge clk) begin
    if (bus.m_we[0]) mem[bus.m_addr[8:1]][7:0]  = bus.m_dout[7:0];
    if (bus.m_we[1]) mem[bus.m_addr[8:1]][15:8] = bus.m_dout[15:8];
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus.i_gnt || bus.d_gnt) chk("gnt_excl", 32'(bus.i_gnt && bus.d_gnt), 0);
      if (bus.i_rvalid || bus.d_rvalid) begin
        chk("rvalid_excl", 32'(bus.i_rvalid && bus.d_rvalid), 0);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_owner", 32'(bus.d_rvalid), 32'(e.own_d));
          if (e.chk_data) chk("sb_rdata", bus.d_rvalid ? bus.d_rdata : bus.i_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    int g, n, last_n;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'hC000 | 16'(i);
      ref_mem[i] = 16'hC000 | 16'(i);
    end
`ifdef ARB_ROUND_ROBIN_EN
    arb_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    arb_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst = 1'b0;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_addr = 0; bus.d_we = 0; bus.d_wdata = 0;
    bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_addr = 0; bus1.d_we = 0;
    bus1.d_wdata = 0;

    // Reset state, with requests pending to show gnt is suppressed.
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus1.i_req = 1'b1;
    @(negedge clk);
    chk("rst_ignt", bus.i_gnt, 0);
    chk("rst_dgnt", bus.d_gnt, 0);
    chk("rst_ignt1", bus1.i_gnt, 0);
    chk("rst_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
    chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    chk("rst_maddr", bus.m_addr, 0);
    chk("rst_mdout", bus.m_dout, 0);
    chk("rst_mctl", {bus.m_oe, bus.m_we}, 0);
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus1.i_req = 1'b0;
    rst = 1'b1;

    // Single-cycle latency fetch.
    @(posedge clk); #1;
    bus1.i_req = 1'b1; bus1.i_addr = 16'h0010;
    @(negedge clk);
    chk("l1_gnt", bus1.i_gnt, 1);
    @(posedge clk); #1;
    bus1.i_req = 1'b0;
    @(negedge clk);
    chk("l1_moe", bus1.m_oe, 1);
    chk("l1_maddr", bus1.m_addr, 16'h0010);
    chk("l1_rvalid_early", bus1.i_rvalid, 0);
    @(negedge clk);
    chk("l1_rvalid", bus1.i_rvalid, 1);
    chk("l1_rdata", bus1.i_rdata, 16'hA5A5);
    chk("l1_moe_off", bus1.m_oe, 0);

    // Byte write: m_we only on the final access cycle.
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_addr = 16'h0100; bus.d_we = 2'b01; bus.d_wdata = 16'h1234;
    @(negedge clk);
    chk("wr_dgnt", bus.d_gnt, 1);
    chk("wr_ignt", bus.i_gnt, 0);
    push_exp(1'b1, 16'h0100, 2'b01, 16'h1234);
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_we = 2'b00;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk("wr_mwe", bus.m_we, (k == LAT) ? 2'b01 : 2'b00);
      chk("wr_rvalid", bus.d_rvalid, 32'(k == LAT + 1));
      if (k <= LAT) chk("wr_maddr", bus.m_addr, 16'h0100);
    end
    drain();
    issue(1'b1, 16'h0100, 2'b00, 16'h0000);
    drain();
    chk("wr_readback_lo", bus.d_rdata[7:0], 8'h34);

    // Simultaneous requests: order after a fresh reset.
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    bus.i_addr = 16'h0020; bus.d_addr = 16'h0100; bus.d_we = 2'b00;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    g = 0; n = 0;
    while (g < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.i_gnt || bus.d_gnt) begin
        chk("arb_order", 32'(bus.d_gnt), 32'(arb_exp[g]));
        push_exp(bus.d_gnt, bus.d_gnt ? bus.d_addr : bus.i_addr, 2'b00, 16'h0000);
        g++;
      end
    end
    chk("arb_count", g, 4);
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    drain();

    // Data request arriving mid-fetch waits for the rvalid cycle.
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 16'h0020;
    @(negedge clk);
    chk("x_ignt", bus.i_gnt, 1);
    push_exp(1'b0, 16'h0020, 2'b00, 16'h0000);
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.d_req = 1'b1; bus.d_addr = 16'h0100; bus.d_we = 2'b00;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("x_dwait", bus.d_gnt, 0);
    end
    @(negedge clk);
    chk("x_dgnt", bus.d_gnt, 1);
    chk("x_irvalid", bus.i_rvalid, 1);
    push_exp(1'b1, 16'h0100, 2'b00, 16'h0000);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    drain();

    // Data request withdrawn before grant is ignored; d_rdata untouched.
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 16'h0030;
    @(negedge clk);
    chk("drop_ignt", bus.i_gnt, 1);
    push_exp(1'b0, 16'h0030, 2'b00, 16'h0000);
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.d_req = 1'b1; bus.d_addr = 16'h0040;
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    repeat (LAT + 3) begin
      @(negedge clk);
      chk("drop_no_dgnt", bus.d_gnt, 0);
    end
    drain();
    chk("drop_drdata_hold", bus.d_rdata, ref_mem[8'h80]);

    // Back-to-back fetches: one grant per LAT+1 cycles, never mid-access.
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 16'h0050;
    g = 0; n = 0; last_n = 0;
    while (g < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.i_gnt) begin
        chk("cont_moe", bus.m_oe, 0);
        if (g > 0) chk("cont_gap", n - last_n, LAT + 1);
        last_n = n;
        push_exp(1'b0, 16'h0050, 2'b00, 16'h0000);
        g++;
      end
    end
    chk("cont_count", g, 4);
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    drain();

    // Reset in the second access cycle of a write aborts it.
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_addr = 16'h0060; bus.d_we = 2'b11; bus.d_wdata = 16'hBEEF;
    @(negedge clk);
    chk("ab_dgnt", bus.d_gnt, 1);
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_we = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("ab_mwe", bus.m_we, 0);
      chk("ab_rvalid", bus.d_rvalid, 0);
    end
    chk("ab_mem_intact", mem[8'h30], ref_mem[8'h30]);
    issue(1'b1, 16'h0060, 2'b00, 16'h0000);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, SHALL set the number of cycles a memory access is held (legal 1..4).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 i_req  in  1  instruction-fetch request, held until granted.
REQ-005 i_addr  in  16  fetch byte address.
REQ-006 i_gnt  out  1  fetch request accepted this cycle.
REQ-007 i_rvalid  out  1  one-cycle pulse: i_rdata valid.
REQ-008 i_rdata  out  16  fetched word.
REQ-009 d_req  in  1  data request, held until granted.
REQ-010 d_addr  in  16  data byte address.
REQ-011 d_we  in  2  byte write enables ([1]=high byte); 2'b00 means read.
REQ-012 d_wdata  in  16  write data.
REQ-013 d_gnt  out  1  data request accepted this cycle.
REQ-014 d_rvalid  out  1  one-cycle completion pulse for reads and writes.
REQ-015 d_rdata  out  16  read word (don't-care on write completion).
REQ-016 m_addr  out  16  shared memory address.
REQ-017 m_oe  out  1  shared memory read enable.
REQ-018 m_we  out  2  shared memory byte write enables.
REQ-019 m_dout  out  16  shared memory write data.
REQ-020 m_din  in  16  shared memory read data, combinationally valid within the cycle.

Function
REQ-021 FSM states SHALL be IDLE and ACCESS only.
REQ-022 In IDLE with any request, exactly one gnt SHALL assert combinationally in that cycle; the winner's address, d_we and d_wdata are latched and the FSM enters ACCESS.
REQ-023 Arbitration without the macro: d_req SHALL win over i_req.
REQ-024 ACCESS SHALL last exactly MEM_LAT cycles, counted by a down-counter loaded with MEM_LAT-1.
REQ-025 During ACCESS: m_addr and m_dout SHALL be driven from the latched values; m_oe=1 for reads; m_we=latched d_we for writes, in the final ACCESS cycle only.
REQ-026 Outside ACCESS: m_oe=0, m_we=2'b00, m_addr and m_dout hold their last value.
REQ-027 On the final ACCESS cycle, m_din SHALL be registered into the owner's rdata, and the owner's rvalid SHALL pulse in the next cycle while the FSM is back in IDLE.
REQ-028 Latency: request granted in cycle t yields rvalid in cycle t+MEM_LAT+1.
REQ-029 A new grant MAY coincide with an rvalid pulse, giving a peak rate of one access per MEM_LAT+1 cycles.
REQ-030 i_gnt and d_gnt SHALL never both be 1; a request arriving during ACCESS SHALL wait with no gnt.
REQ-031 The non-owner's rdata SHALL hold its previous value.
REQ-032 A requester dropping req before its grant SHALL be ignored without error.

Reset
REQ-033 While rst=0 at a clock edge: FSM=IDLE, counter=0, and all registered outputs cleared (rvalids 0, rdatas 0, m_addr 0, m_dout 0).
REQ-034 Reset in mid-ACCESS SHALL abort the access: no rvalid, and m_we=2'b00 from the next cycle.
REQ-035 gnt outputs SHALL be 0 while rst=0.

Configuration
REQ-036 With ARB_ROUND_ROBIN_EN defined: a last-owner flag (reset: I) SHALL make a simultaneous i_req/d_req grant the port not granted last; without the macro, REQ-023 applies and the flag is absent.

Structure
REQ-037 Package mem_arb_pkg SHALL hold typedef enum arb_state_t {IDLE, ACCESS}, typedef enum owner_t {OWN_I, OWN_D}, and constant MEM_LAT_MAX=4.
REQ-038 One combinational sub-module, arb_pick (inputs i_req, d_req, last owner; output winner), SHALL contain the priority/round-robin decision.

Verification
REQ-039 MEM_LAT=1, i_req alone with i_addr=16'h0010 and memory word 16'hA5A5 -> i_gnt at t, m_oe at t+1, i_rvalid with i_rdata=16'hA5A5 at t+2.
REQ-040 MEM_LAT=3, d write d_addr=16'h0100, d_we=2'b01, d_wdata=16'h1234 -> m_we=2'b01 only at t+3, d_rvalid at t+4, byte 16'h0100 low half reads back 16'h34.
REQ-041 i_req and d_req high together for 4 grants -> default build: D,D,D,D (I starved); ARB_ROUND_ROBIN_EN build: D,I,D,I.
REQ-042 d_req raised during an I ACCESS -> no d_gnt until the cycle of i_rvalid, then d_gnt is asserted in that same cycle.
REQ-043 rst=0 asserted in the second of three ACCESS cycles of a write -> no d_rvalid, m_we=2'b00 thereafter, FSM in IDLE.
REQ-044 Continuous i_req, MEM_LAT=2 -> i_gnt every 3 cycles, with gnt never coinciding with an ACCESS cycle.
